// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage issue/resolve wrapper around an external combinational ALU.
// Stage A holds the accepted op and drives the ALU; stage B registers the resolved packet.
module alu_issue_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7b5,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_funsel,
    input  logic [XLEN-1:0] alu_out,
    input  logic [2:0]      alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [3:0] FnAnd  = 4'b0000;
    localparam logic [3:0] FnOr   = 4'b0001;
    localparam logic [3:0] FnAdd  = 4'b0010;
    localparam logic [3:0] FnSub  = 4'b0110;
    localparam logic [3:0] FnSlt  = 4'b0111;
    localparam logic [3:0] FnSltu = 4'b1000;
    localparam logic [3:0] FnSll  = 4'b1001;
    localparam logic [3:0] FnSr   = 4'b1011;
    localparam logic [3:0] FnXor  = 4'b1100;

    localparam logic [2:0] CmpLess  = 3'b100;
    localparam logic [2:0] CmpEqual = 3'b010;

    logic            a_valid_q;
    logic [6:0]      a_opcode_q;
    logic [2:0]      a_funct3_q;
    logic            a_funct7b5_q;
    logic [XLEN-1:0] a_rs1_q, a_rs2_q, a_imm_q, a_pc_q;
    logic [4:0]      a_rd_q;
    logic            b_valid_q;
    logic            b_can_take;

    logic dec_illegal, dec_wb, dec_cmp, dec_sra, dec_branch, dec_jal, dec_jalr;
    logic [XLEN-1:0] res_result, res_target;
    logic            res_we, res_taken;

    assign b_can_take = !b_valid_q || out_ready;
    assign in_ready   = !a_valid_q || b_can_take;
    assign out_valid  = b_valid_q;

    // Stage A: accept a new op whenever the slot is free or draining into stage B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q    <= 1'b0;
            a_opcode_q   <= '0;
            a_funct3_q   <= '0;
            a_funct7b5_q <= 1'b0;
            a_rs1_q      <= '0;
            a_rs2_q      <= '0;
            a_imm_q      <= '0;
            a_pc_q       <= '0;
            a_rd_q       <= '0;
        end else if (in_flush) begin
            a_valid_q <= 1'b0;
        end else if (in_ready) begin
            a_valid_q <= in_valid;
            if (in_valid) begin
                a_opcode_q   <= in_opcode;
                a_funct3_q   <= in_funct3;
                a_funct7b5_q <= in_funct7b5;
                a_rs1_q      <= in_rs1;
                a_rs2_q      <= in_rs2;
                a_imm_q      <= in_imm;
                a_pc_q       <= in_pc;
                a_rd_q       <= in_rd;
            end
        end
    end

    // Decode stage A into ALU operands/function and per-class flags; depends only on A registers.
    always_comb begin
        alu_in1     = '0;
        alu_in2     = '0;
        alu_funsel  = FnAnd;
        dec_illegal = 1'b0;
        dec_wb      = 1'b0;
        dec_cmp     = 1'b0;
        dec_sra     = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_jalr    = 1'b0;
        if (a_valid_q) begin
            case (a_opcode_q)
                OpcOp, OpcOpImm: begin
                    dec_wb  = 1'b1;
                    alu_in1 = a_rs1_q;
                    alu_in2 = (a_opcode_q == OpcOp) ? a_rs2_q : a_imm_q;
                    case (a_funct3_q)
                        3'b000: alu_funsel = (a_opcode_q == OpcOp && a_funct7b5_q) ? FnSub : FnAdd;
                        3'b001: begin
                            alu_funsel  = FnSll;
                            alu_in2     = {{(XLEN-5){1'b0}}, alu_in2[4:0]};
                            dec_illegal = a_funct7b5_q;
                        end
                        3'b010: begin alu_funsel = FnSlt;  dec_cmp = 1'b1; end
                        3'b011: begin alu_funsel = FnSltu; dec_cmp = 1'b1; end
                        3'b100: alu_funsel = FnXor;
                        3'b101: begin
                            // ALU shifts logically; arithmetic fill is patched in on resolve
                            alu_funsel = FnSr;
                            alu_in2    = {{(XLEN-5){1'b0}}, alu_in2[4:0]};
                            dec_sra    = a_funct7b5_q;
                        end
                        3'b110: alu_funsel = FnOr;
                        default: alu_funsel = FnAnd;
                    endcase
                    // instr[30] in OP only qualifies SUB and SRA
                    if (a_opcode_q == OpcOp && a_funct7b5_q &&
                        a_funct3_q != 3'b000 && a_funct3_q != 3'b101) begin
                        dec_illegal = 1'b1;
                    end
                end
                OpcLui: begin
                    dec_wb = 1'b1; alu_in2 = a_imm_q; alu_funsel = FnAdd;
                end
                OpcAuipc: begin
                    dec_wb = 1'b1; alu_in1 = a_pc_q; alu_in2 = a_imm_q; alu_funsel = FnAdd;
                end
                OpcJal: begin
                    dec_wb = 1'b1; dec_jal = 1'b1;
                    alu_in1 = a_pc_q; alu_in2 = a_imm_q; alu_funsel = FnAdd;
                end
                OpcJalr: begin
                    dec_wb = 1'b1; dec_jalr = 1'b1;
                    alu_in1 = a_rs1_q; alu_in2 = a_imm_q; alu_funsel = FnAdd;
                    dec_illegal = (a_funct3_q != 3'b000);
                end
                OpcBranch: begin
                    dec_branch = 1'b1;
                    alu_in1    = a_rs1_q;
                    alu_in2    = a_rs2_q;
                    alu_funsel = a_funct3_q[1] ? FnSltu : FnSlt;
                    dec_illegal = (a_funct3_q == 3'b010 || a_funct3_q == 3'b011);
                end
                default: dec_illegal = 1'b1;
            endcase
            if (dec_illegal) begin
                alu_in1    = '0;
                alu_in2    = '0;
                alu_funsel = FnAnd;
            end
        end
    end

    // Resolve the ALU response into the writeback/branch packet.
    always_comb begin
        res_result = '0;
        res_target = '0;
        res_we     = 1'b0;
        res_taken  = 1'b0;
        if (a_valid_q && !dec_illegal) begin
            res_we = dec_wb && (a_rd_q != 5'd0);
            if (dec_branch) begin
                res_target = a_pc_q + a_imm_q;
                case (a_funct3_q)
                    3'b000:          res_taken = (alu_zero == CmpEqual);
                    3'b001:          res_taken = (alu_zero != CmpEqual);
                    3'b100, 3'b110:  res_taken = (alu_zero == CmpLess);
                    default:         res_taken = (alu_zero != CmpLess);
                endcase
            end else if (dec_jal || dec_jalr) begin
                res_taken  = 1'b1;
                res_target = dec_jal ? (a_pc_q + a_imm_q) : (alu_out & ~{{(XLEN-1){1'b0}}, 1'b1});
                res_result = a_pc_q + 32'd4;
            end else if (dec_cmp) begin
                res_result = {{(XLEN-1){1'b0}}, (alu_zero == CmpLess)};
            end else if (dec_sra) begin
                res_result = alu_out | (a_rs1_q[XLEN-1] ? ~({XLEN{1'b1}} >> alu_in2[4:0]) : '0);
            end else begin
                res_result = alu_out;
            end
        end
    end

    // Stage B: capture the resolved packet; hold it while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_q   <= 1'b0;
            out_result  <= '0;
            out_rd      <= '0;
            out_we      <= 1'b0;
            out_taken   <= 1'b0;
            out_target  <= '0;
            out_illegal <= 1'b0;
        end else if (in_flush) begin
            b_valid_q <= 1'b0;
        end else if (b_can_take) begin
            b_valid_q <= a_valid_q;
            if (a_valid_q) begin
                out_result  <= res_result;
                out_rd      <= a_rd_q;
                out_we      <= res_we;
                out_taken   <= res_taken;
                out_target  <= res_target;
                out_illegal <= dec_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: behavioural ALU, instruction-level reference model, scoreboard.
module tb_alu_issue_stage;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        b5;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
    } op_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] target;
        logic        illegal;
    } pkt_t;

    logic        clk, rst_n, in_flush, in_valid, in_ready, in_funct7b5;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1, in_rs2, in_imm, in_pc;
    logic [4:0]  in_rd;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_funsel;
    logic [2:0]  alu_zero;
    logic        out_valid, out_ready, out_we, out_taken, out_illegal;
    logic [31:0] out_result, out_target;
    logic [4:0]  out_rd;

    int   n_tests = 0;
    int   n_fail  = 0;
    pkt_t exp_q[$];
    op_t  cur_op;
    logic acc_flag;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_flush(in_flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funsel(alu_funsel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_we(out_we), .out_taken(out_taken), .out_target(out_target),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_funsel)
            4'b0000: alu_out = alu_in1 & alu_in2;
            4'b0001: alu_out = alu_in1 | alu_in2;
            4'b0010: alu_out = alu_in1 + alu_in2;
            4'b0110: alu_out = alu_in1 - alu_in2;
            4'b1001: alu_out = alu_in1 << alu_in2[4:0];
            4'b1011: alu_out = alu_in1 >> alu_in2[4:0];
            4'b1100: alu_out = alu_in1 ^ alu_in2;
            default: alu_out = 32'd0;
        endcase
        if (alu_in1 == alu_in2) alu_zero = 3'b010;
        else if (alu_funsel == 4'b1000) alu_zero = (alu_in1 < alu_in2) ? 3'b100 : 3'b001;
        else alu_zero = ($signed(alu_in1) < $signed(alu_in2)) ? 3'b100 : 3'b001;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic [4:0] rd);
        op_t o;
        o.opcode = opc; o.funct3 = f3; o.b5 = b5; o.rs1 = rs1; o.rs2 = rs2;
        o.imm = imm; o.pc = pc; o.rd = rd;
        return o;
    endfunction

    // Instruction-level reference model
    function automatic pkt_t model(input op_t o);
        pkt_t p;
        logic [31:0] b;
        logic signed [31:0] sr;
        logic ill, wb;
        p = '0; ill = 1'b0; wb = 1'b0; b = '0;
        case (o.opcode)
            OpcOp, OpcOpImm: begin
                wb = 1'b1;
                b  = (o.opcode == OpcOp) ? o.rs2 : o.imm;
                case (o.funct3)
                    3'd0: p.result = (o.opcode == OpcOp && o.b5) ? o.rs1 - b : o.rs1 + b;
                    3'd1: begin p.result = o.rs1 << b[4:0]; ill = o.b5; end
                    3'd2: p.result = ($signed(o.rs1) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: p.result = (o.rs1 < b) ? 32'd1 : 32'd0;
                    3'd4: p.result = o.rs1 ^ b;
                    3'd5: begin
                        if (o.b5) begin
                            sr = $signed(o.rs1) >>> b[4:0];
                            p.result = sr;
                        end else begin
                            p.result = o.rs1 >> b[4:0];
                        end
                    end
                    3'd6: p.result = o.rs1 | b;
                    default: p.result = o.rs1 & b;
                endcase
                if (o.opcode == OpcOp && o.b5 && o.funct3 != 3'd0 && o.funct3 != 3'd5) ill = 1'b1;
            end
            OpcLui:   begin wb = 1'b1; p.result = o.imm; end
            OpcAuipc: begin wb = 1'b1; p.result = o.pc + o.imm; end
            OpcJal: begin
                wb = 1'b1; p.taken = 1'b1; p.result = o.pc + 32'd4; p.target = o.pc + o.imm;
            end
            OpcJalr: begin
                wb = 1'b1; p.taken = 1'b1; p.result = o.pc + 32'd4;
                p.target = (o.rs1 + o.imm) & 32'hFFFF_FFFE;
                ill = (o.funct3 != 3'd0);
            end
            OpcBranch: begin
                p.target = o.pc + o.imm;
                case (o.funct3)
                    3'd0: p.taken = (o.rs1 == o.rs2);
                    3'd1: p.taken = (o.rs1 != o.rs2);
                    3'd4: p.taken = ($signed(o.rs1) < $signed(o.rs2));
                    3'd5: p.taken = ($signed(o.rs1) >= $signed(o.rs2));
                    3'd6: p.taken = (o.rs1 < o.rs2);
                    3'd7: p.taken = (o.rs1 >= o.rs2);
                    default: ill = 1'b1;
                endcase
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            p = '0;
            p.illegal = 1'b1;
        end else begin
            p.rd = o.rd;
            p.we = wb && (o.rd != 5'd0);
        end
        return p;
    endfunction

    task automatic drive(input op_t o);
        cur_op = o;
        in_opcode = o.opcode; in_funct3 = o.funct3; in_funct7b5 = o.b5;
        in_rs1 = o.rs1; in_rs2 = o.rs2; in_imm = o.imm; in_pc = o.pc; in_rd = o.rd;
    endtask

    // One clock: inputs set at the falling edge, acceptance/output sampled just after it.
    task automatic cycle();
        pkt_t e;
        #1;
        acc_flag = in_valid && in_ready && !in_flush;
        if (acc_flag) exp_q.push_back(model(cur_op));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("illegal", {31'd0, out_illegal}, {31'd0, e.illegal});
                if (!e.illegal) check_eq("rd", {27'd0, out_rd}, {27'd0, e.rd});
                check_eq("result", out_result, e.result);
                check_eq("we", {31'd0, out_we}, {31'd0, e.we});
                check_eq("taken", {31'd0, out_taken}, {31'd0, e.taken});
                check_eq("target", out_target, e.target);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input op_t o);
        int budget;
        budget = 20;
        drive(o);
        in_valid = 1'b1;
        do begin
            cycle();
            budget--;
        end while (!acc_flag && budget > 0);
        if (!acc_flag) check_eq("accept_timeout", {31'd0, acc_flag}, 32'd1);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check_eq("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        op_t adds[4];
        int  idx, budget;

        rst_n = 1'b0; in_flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(mk(7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0));
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_funsel", {28'd0, alu_funsel}, 32'd0);
        check_eq("rst_alu_in1", alu_in1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // ADD latency and ALU drive
        out_ready = 1'b1;
        drive(mk(OpcOp, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3));
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        check_eq("add_funsel", {28'd0, alu_funsel}, 32'h2);
        check_eq("add_in1", alu_in1, 32'd5);
        check_eq("add_in2", alu_in2, 32'd7);
        check_eq("add_early_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        check_eq("add_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // Compares, shifts, branches, jumps, misc, back-to-back
        send(mk(OpcOp,    3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd4));
        send(mk(OpcOp,    3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd5));
        send(mk(OpcOpImm, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 5'd0));
        send(mk(OpcOp,    3'd5, 1'b1, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd6));
        send(mk(OpcOp,    3'd5, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 5'd7));
        send(mk(OpcOpImm, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'h400, 32'd0, 5'd8));
        send(mk(OpcBranch, 3'd1, 1'b0, 32'd9, 32'd9, 32'h10, 32'h80, 5'd0));
        send(mk(OpcBranch, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 5'd0));
        send(mk(OpcBranch, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 5'd0));
        send(mk(OpcBranch, 3'd0, 1'b0, 32'd3, 32'd3, 32'hFFFF_FFF0, 32'h200, 5'd0));
        send(mk(OpcJal,   3'd0, 1'b0, 32'd0, 32'd0, 32'h40, 32'h200, 5'd1));
        send(mk(OpcJalr,  3'd0, 1'b0, 32'h301, 32'd0, 32'h10, 32'h300, 5'd2));
        send(mk(OpcLui,   3'd0, 1'b0, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 5'd9));
        send(mk(OpcAuipc, 3'd0, 1'b0, 32'd0, 32'd0, 32'h2000, 32'h1000, 5'd10));
        send(mk(OpcOp,    3'd0, 1'b1, 32'd10, 32'd3, 32'd0, 32'd0, 5'd11));
        send(mk(OpcOp,    3'd1, 1'b0, 32'h1, 32'd33, 32'd0, 32'd0, 5'd12));
        send(mk(OpcOpImm, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'd0, 32'hFFFF_FFFF, 32'd0, 5'd13));
        send(mk(OpcOp,    3'd4, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 5'd14));
        send(mk(7'b1111111, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 5'd15));
        drain();

        // Backpressure: 4 ADDs, consumer stalled for 3 cycles
        for (int i = 0; i < 4; i++) begin
            adds[i] = mk(OpcOp, 3'd0, 1'b0, 32'(100 * (i + 1)), 32'(i + 1), 32'd0, 32'd0,
                         5'(i + 16));
        end
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(adds[idx]);
            in_valid = 1'b1;
            cycle();
            if (acc_flag) idx++;
        end
        check_eq("stall_accepts", 32'(idx), 32'd2);
        drive(adds[idx]);
        #1;
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall_out_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        budget = 20;
        while (idx < 4 && budget > 0) begin
            drive(adds[idx]);
            in_valid = 1'b1;
            cycle();
            if (acc_flag) idx++;
            budget--;
        end
        check_eq("stream_accepts", 32'(idx), 32'd4);
        drain();

        // Flush with both stages full and a new op offered
        out_ready = 1'b0;
        send(mk(OpcOp, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd1));
        send(mk(OpcOp, 3'd0, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd2));
        check_eq("preflush_valid", {31'd0, out_valid}, 32'd1);
        drive(mk(OpcOp, 3'd0, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 5'd3));
        in_valid = 1'b1;
        in_flush = 1'b1;
        cycle();
        in_flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_eq("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("flush_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        check_eq("postflush_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(mk(OpcJal, 3'd0, 1'b0, 32'd0, 32'd0, 32'h40, 32'h200, 5'd1));
        send(mk(OpcOp, 3'd0, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd2));
        in_valid = 1'b0;
        check_eq("prerst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("arst_result", out_result, 32'd0);
        check_eq("arst_we", {31'd0, out_we}, 32'd0);
        check_eq("arst_taken", {31'd0, out_taken}, 32'd0);
        check_eq("arst_target", out_target, 32'd0);
        check_eq("arst_alu_in1", alu_in1, 32'd0);
        check_eq("arst_alu_in2", alu_in2, 32'd0);
        check_eq("arst_funsel", {28'd0, alu_funsel}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        send(mk(OpcOp, 3'd7, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'd0, 5'd31));
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
